// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//   Loads a program from the UART byte stream into instruction memory.
//   A CMD_LOAD byte starts a load. The following bytes are packed MSB first
//   into WBITS-wide words. Each word goes to consecutive memory addresses,
//   starting at 0. The load ends when a HALT_WORD has been written, or when
//   the last memory location has been written with a non-HALT word
//   (overflow). The CPU is held off through o_loading while a load runs.
//
// Ports
//   i_clk         : system clock, rising edge
//   i_reset       : synchronous active-high reset
//   i_rx_data     : received UART byte
//   i_rx_valid    : one-cycle strobe qualifying i_rx_data
//   o_mem_wr_en   : one-cycle instruction-memory write strobe
//   o_mem_addr    : word address of the write
//   o_mem_data    : instruction word of the write
//   o_loading     : high while a load is in progress
//   o_done        : high once a load has finished
//   o_overflow    : memory filled before HALT; sticky until the next load
//   o_word_count  : words written by the current/last load, HALT included
//
// WBITS must equal 4*DBITS. The byte counter assumes four bytes per word.
// -----------------------------------------------------------------------------
module instr_loader #(
    parameter int                DBITS     = 8,
    parameter int                WBITS     = 32,
    parameter int                ADDR_BITS = 8,
    parameter logic [DBITS-1:0]  CMD_LOAD  = 8'h4C,
    parameter logic [WBITS-1:0]  HALT_WORD = 32'hFFFFFFFF
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [DBITS-1:0]     i_rx_data,
    input  logic                 i_rx_valid,
    output logic                 o_mem_wr_en,
    output logic [ADDR_BITS-1:0] o_mem_addr,
    output logic [WBITS-1:0]     o_mem_data,
    output logic                 o_loading,
    output logic                 o_done,
    output logic                 o_overflow,
    output logic [ADDR_BITS:0]   o_word_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [ADDR_BITS-1:0] ADDR_MAX = {ADDR_BITS{1'b1}};
    localparam logic [ADDR_BITS-1:0] IDX_ONE  = {{(ADDR_BITS-1){1'b0}}, 1'b1};
    localparam logic [ADDR_BITS:0]   CNT_ONE  = {{ADDR_BITS{1'b0}}, 1'b1};

    state_e                 state_q;
    logic [1:0]             byte_cnt_q;
    logic [ADDR_BITS-1:0]   word_idx_q;
    logic [WBITS-1:0]       asm_q;
    logic                   mem_wr_en_q;
    logic [ADDR_BITS-1:0]   mem_addr_q;
    logic [WBITS-1:0]       mem_data_q;
    logic                   loading_q;
    logic                   done_q;
    logic                   overflow_q;
    logic [ADDR_BITS:0]     word_count_q;

    logic                   is_cmd_s;
    logic [WBITS-1:0]       asm_next_s;
    logic                   finish_s;

    assign is_cmd_s   = i_rx_valid && (i_rx_data == CMD_LOAD);
    // The newest byte enters at the bottom, so the first byte of a word
    // ends up in the top byte once four bytes have arrived.
    assign asm_next_s = {asm_q[WBITS-DBITS-1:0], i_rx_data};
    // Decided in the write-strobe cycle. The word being written is either
    // HALT, or it fills the last location. A word at ADDR_MAX that is not
    // HALT is the overflow case.
    assign finish_s   = mem_wr_en_q &&
                        ((mem_data_q == HALT_WORD) || (mem_addr_q == ADDR_MAX));

    // Load controller: state, byte assembly, write strobe and status outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            byte_cnt_q   <= 2'd0;
            word_idx_q   <= '0;
            asm_q        <= '0;
            mem_wr_en_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            loading_q    <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            word_count_q <= '0;
        end else begin
            mem_wr_en_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (is_cmd_s) begin
                        state_q      <= ST_LOAD;
                        loading_q    <= 1'b1;
                        done_q       <= 1'b0;
                        byte_cnt_q   <= 2'd0;
                        word_idx_q   <= '0;
                        word_count_q <= '0;
                        overflow_q   <= 1'b0;
                    end else begin
                        state_q <= state_q;
                    end
                end
                ST_LOAD: begin
                    if (finish_s) begin
                        // A byte arriving in this cycle is dropped, because
                        // the load ends here.
                        state_q    <= ST_DONE;
                        loading_q  <= 1'b0;
                        done_q     <= 1'b1;
                        overflow_q <= (mem_data_q != HALT_WORD);
                    end else if (i_rx_valid) begin
                        // CMD_LOAD is ordinary data here. The write-strobe
                        // cycle also accepts a byte, so collection never stalls.
                        asm_q <= asm_next_s;
                        if (byte_cnt_q == 2'd3) begin
                            mem_wr_en_q  <= 1'b1;
                            mem_data_q   <= asm_next_s;
                            mem_addr_q   <= word_idx_q;
                            word_count_q <= word_count_q + CNT_ONE;
                            byte_cnt_q   <= 2'd0;
                            // The index saturates. A write at ADDR_MAX always
                            // ends the load.
                            if (word_idx_q != ADDR_MAX) begin
                                word_idx_q <= word_idx_q + IDX_ONE;
                            end else begin
                                word_idx_q <= word_idx_q;
                            end
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                        end
                    end else begin
                        byte_cnt_q <= byte_cnt_q;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    loading_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign o_mem_wr_en  = mem_wr_en_q;
    assign o_mem_addr   = mem_addr_q;
    assign o_mem_data   = mem_data_q;
    assign o_loading    = loading_q;
    assign o_done       = done_q;
    assign o_overflow   = overflow_q;
    assign o_word_count = word_count_q;

endmodule
